// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the transmitter, receiver and their FIFO.
package uart_pkg;

  localparam int BAUD_DIV      = 868;
  localparam int CLK_PERIOD    = 10;
  localparam int RX_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_if.sv
// UART signal bundle; the master modport is the bench/host side of the receiver.
interface uart_if (
  input logic clk_i
);

  logic       rst_ni;
  logic       rx_en_i;
  logic       rx_bit_i;
  logic       rx_re_i;
  logic [7:0] dout_o;
  logic       empty_o;
  logic       full_o;
  logic       busy_o;
  logic       frame_err_o;
  logic       overrun_o;

  modport master (
    input  clk_i,
    output rst_ni, rx_en_i, rx_bit_i, rx_re_i,
    input  dout_o, empty_o, full_o, busy_o, frame_err_o, overrun_o
  );

  modport dut (
    input  clk_i, rst_ni, rx_en_i, rx_bit_i, rx_re_i,
    output dout_o, empty_o, full_o, busy_o, frame_err_o, overrun_o
  );

endinterface

// File: rtl/uart_fifo.sv
// First-word-fall-through synchronous FIFO, shared by the UART transmitter and receiver.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra MSB on each pointer separates full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = re && !empty;
  assign do_push = we && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, samples mid-bit and queues bytes in a FWFT FIFO.
module uart_rx #(
  parameter int BAUD_DIV   = uart_pkg::BAUD_DIV,
  parameter int FIFO_DEPTH = uart_pkg::RX_FIFO_DEPTH
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_en_i,
  input  logic       rx_bit_i,
  input  logic       rx_re_i,
  output logic [7:0] dout_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  import uart_pkg::*;

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_TGT = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TGT = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (BAUD_DIV < 4) begin : g_bad_baud
    $error("uart_rx: BAUD_DIV must be at least 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx: FIFO_DEPTH must be a power of two and at least 2");
  end

  rx_state_e        state_q;
  rx_state_e        state_d;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             baud_tick;
  logic             shift_en;
  logic             push;
  logic             frame_err_d;
  logic             overrun_d;

  // Idle-high reset values keep a quiet line from looking like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_bit_i;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_tick   = 1'b0;
    shift_en    = 1'b0;
    push        = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_en_i && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        baud_tick = (baud_cnt == HALF_TGT);
        if (baud_tick) state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        baud_tick = (baud_cnt == FULL_TGT);
        if (baud_tick) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        baud_tick = (baud_cnt == FULL_TGT);
        // Leaving at mid-stop gives half a bit of slack before a back-to-back start edge.
        if (baud_tick) begin
          state_d = RX_IDLE;
          if (!rx_s)                 frame_err_d = 1'b1;
          else if (!full_o || rx_re_i) push      = 1'b1;
          else                       overrun_d   = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RX_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_err_o <= frame_err_d;
      overrun_o   <= overrun_d;
      if (state_q == RX_IDLE || state_d != state_q || baud_tick) baud_cnt <= '0;
      else                                                       baud_cnt <= baud_cnt + CNT_ONE;
      if (state_q == RX_START) bit_cnt <= '0;
      else if (shift_en)       bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shift_reg[bit_cnt] <= rx_s;
    end
  end

  assign busy_o = (state_q != RX_IDLE);

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .we     (push),
    .re     (rx_re_i),
    .din    (shift_reg),
    .dout   (dout_o),
    .empty  (empty_o),
    .full   (full_o)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames in, popped bytes and error pulses out.
module tb_uart_rx;

  localparam int B       = 16;
  localparam int D       = 4;
  localparam int POP_CYC = 2 + B / 2 + 9 * B;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_en;
  logic       rx_bit;
  logic       rx_re;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int exp_fe = 0;
  int exp_ov = 0;
  int fe_cnt = 0, fe_run = 0, fe_maxrun = 0;
  int ov_cnt = 0, ov_run = 0, ov_maxrun = 0;
  int idle_run = 0, idle_maxrun = 0;
  bit track_idle = 1'b0;
  logic [7:0] model_q [$];

  always #5 clk = ~clk;

  uart_rx #(
    .BAUD_DIV   (B),
    .FIFO_DEPTH (D)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_en_i     (rx_en),
    .rx_bit_i    (rx_bit),
    .rx_re_i     (rx_re),
    .dout_o      (dout),
    .empty_o     (empty),
    .full_o      (full),
    .busy_o      (busy),
    .frame_err_o (frame_err),
    .overrun_o   (overrun)
  );

  // Pulse counting and idle-gap measurement, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err) begin
      if (fe_run == 0) fe_cnt++;
      fe_run++;
      if (fe_run > fe_maxrun) fe_maxrun = fe_run;
    end else fe_run = 0;
    if (overrun) begin
      if (ov_run == 0) ov_cnt++;
      ov_run++;
      if (ov_run > ov_maxrun) ov_maxrun = ov_run;
    end else ov_run = 0;
    if (track_idle && !busy) begin
      idle_run++;
      if (idle_run > idle_maxrun) idle_maxrun = idle_run;
    end else idle_run = 0;
  end

  // Receiver behaviour at frame granularity: bad stop drops, full FIFO drops unless popped.
  function automatic void model_frame(input logic [7:0] d, input logic stop_ok, input logic pop_same);
    if (!stop_ok) exp_fe++;
    else begin
      if (pop_same && model_q.size() > 0) void'(model_q.pop_front());
      if (model_q.size() < D) model_q.push_back(d);
      else exp_ov++;
    end
  endfunction

  task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input int max_cyc, input int pop_cyc);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int c = 0; c < 10 * B && c < max_cyc; c++) begin
      @(negedge clk);
      rx_bit = bits[4'(c / B)];
      rx_re  = (c == pop_cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_bit = 1'b1;
      rx_re  = 1'b0;
    end
  endtask

  task automatic pop_byte(output logic [7:0] got, output logic was_empty);
    @(negedge clk);
    got       = dout;
    was_empty = empty;
    rx_re     = 1'b1;
    @(negedge clk);
    rx_re     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dout, empty, full, busy, frame_err, overrun} !== {8'h00, 5'b10000}) begin
      errors++;
      $display("[TB] FAIL reset_during got=%h required=%h", {dout, empty, full, busy, frame_err, overrun}, {8'h00, 5'b10000});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    checks++;
    if ({dout, empty, full, busy, frame_err, overrun} !== {8'h00, 5'b10000}) begin
      errors++;
      $display("[TB] FAIL reset_after got=%h required=%h", {dout, empty, full, busy, frame_err, overrun}, {8'h00, 5'b10000});
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] got, exp;
    logic       was_empty;
    drive_frame(8'h41, 1'b1, 10 * B, -1);
    model_frame(8'h41, 1'b1, 1'b0);
    idle(4);
    checks++;
    if ({empty, dout} !== {1'b0, 8'h41}) begin
      errors++;
      $display("[TB] FAIL single_head got empty=%b dout=%h required empty=0 dout=41", empty, dout);
    end
    checks++;
    if (fe_cnt !== exp_fe || ov_cnt !== exp_ov) begin
      errors++;
      $display("[TB] FAIL single_flags got fe=%0d ov=%0d required fe=%0d ov=%0d", fe_cnt, ov_cnt, exp_fe, exp_ov);
    end
    exp = model_q.pop_front();
    pop_byte(got, was_empty);
    checks++;
    if (was_empty !== 1'b0 || got !== exp) begin
      errors++;
      $display("[TB] FAIL single_pop got %h (empty=%b) required %h", got, was_empty, exp);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_empty got empty=%b required 1", empty);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, exp;
    logic       was_empty;
    logic [7:0] bytes [4];
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++)
        bytes[i] = (r == 0) ? ((i == 3) ? 8'h0A : 8'(8'h41 + i)) : 8'($urandom_range(0, 255));
      idle_maxrun = 0;
      for (int i = 0; i < 4; i++) begin
        drive_frame(bytes[i], 1'b1, 10 * B, -1);
        model_frame(bytes[i], 1'b1, 1'b0);
        track_idle = 1'b1;
      end
      track_idle = 1'b0;
      idle(4);
      checks++;
      if (idle_maxrun > B) begin
        errors++;
        $display("[TB] FAIL b2b_gap got idle run %0d cycles required <= %0d", idle_maxrun, B);
      end
      checks++;
      if (full !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_full got full=%b required 1", full);
      end
      while (model_q.size() > 0) begin
        exp = model_q.pop_front();
        pop_byte(got, was_empty);
        checks++;
        if (was_empty !== 1'b0 || got !== exp) begin
          errors++;
          $display("[TB] FAIL b2b_order got %h (empty=%b) required %h", got, was_empty, exp);
        end
      end
    end
  endtask

  task automatic test_glitch();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rx_bit = 1'b0;
    end
    idle(2 * B);
    checks++;
    if ({busy, empty, fe_cnt == exp_fe, ov_cnt == exp_ov} !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL glitch got busy=%b empty=%b fe=%0d ov=%0d required busy=0 empty=1 fe=%0d ov=%0d",
               busy, empty, fe_cnt, ov_cnt, exp_fe, exp_ov);
    end
    rx_en = 1'b0;
    drive_frame(8'h12, 1'b1, 10 * B, -1);
    idle(4);
    checks++;
    if ({busy, empty} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL disabled got busy=%b empty=%b required busy=0 empty=1", busy, empty);
    end
    rx_en = 1'b1;
  endtask

  task automatic test_frame_error();
    logic [7:0] got, exp;
    logic       was_empty;
    fe_maxrun = 0;
    drive_frame(8'h55, 1'b0, 10 * B, -1);
    model_frame(8'h55, 1'b0, 1'b0);
    idle(2 * B);
    checks++;
    if (fe_cnt !== exp_fe || fe_maxrun !== 1) begin
      errors++;
      $display("[TB] FAIL frame_err_pulse got count=%0d width=%0d required count=%0d width=1", fe_cnt, fe_maxrun, exp_fe);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL frame_err_fifo got empty=%b required 1", empty);
    end
    drive_frame(8'hAA, 1'b1, 10 * B, -1);
    model_frame(8'hAA, 1'b1, 1'b0);
    idle(4);
    exp = model_q.pop_front();
    pop_byte(got, was_empty);
    checks++;
    if (was_empty !== 1'b0 || got !== exp || fe_cnt !== exp_fe) begin
      errors++;
      $display("[TB] FAIL frame_err_recover got %h (empty=%b fe=%0d) required %h fe=%0d", got, was_empty, fe_cnt, exp, exp_fe);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] got, exp;
    logic       was_empty;
    for (int r = 0; r < 2; r++) begin
      ov_maxrun = 0;
      for (int i = 1; i <= 4; i++) begin
        drive_frame(8'(i), 1'b1, 10 * B, -1);
        model_frame(8'(i), 1'b1, 1'b0);
      end
      idle(2);
      checks++;
      if (full !== 1'b1) begin
        errors++;
        $display("[TB] FAIL overrun_full got full=%b required 1", full);
      end
      drive_frame(8'h05, 1'b1, 10 * B, (r == 1) ? POP_CYC : -1);
      model_frame(8'h05, 1'b1, r == 1);
      idle(4);
      checks++;
      if (ov_cnt !== exp_ov || (r == 0 && ov_maxrun !== 1)) begin
        errors++;
        $display("[TB] FAIL overrun_pulse round %0d got count=%0d width=%0d required count=%0d", r, ov_cnt, ov_maxrun, exp_ov);
      end
      while (model_q.size() > 0) begin
        exp = model_q.pop_front();
        pop_byte(got, was_empty);
        checks++;
        if (was_empty !== 1'b0 || got !== exp) begin
          errors++;
          $display("[TB] FAIL overrun_drain round %0d got %h (empty=%b) required %h", r, got, was_empty, exp);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] got, exp, d;
    logic       was_empty, ok;
    for (int i = 0; i < 14; i++) begin
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      drive_frame(d, ok, 10 * B, -1);
      model_frame(d, ok, 1'b0);
      idle(ok ? $urandom_range(0, B) : B);
      if ($urandom_range(0, 1) == 1) begin
        pop_byte(got, was_empty);
        checks++;
        if (model_q.size() == 0) begin
          if (was_empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL random_underflow got empty=%b required 1", was_empty);
          end
        end else begin
          exp = model_q.pop_front();
          if (was_empty !== 1'b0 || got !== exp) begin
            errors++;
            $display("[TB] FAIL random_pop got %h (empty=%b) required %h", got, was_empty, exp);
          end
        end
      end
    end
    idle(4);
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      pop_byte(got, was_empty);
      checks++;
      if (was_empty !== 1'b0 || got !== exp) begin
        errors++;
        $display("[TB] FAIL random_drain got %h (empty=%b) required %h", got, was_empty, exp);
      end
    end
    checks++;
    if (fe_cnt !== exp_fe || ov_cnt !== exp_ov || empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL random_flags got fe=%0d ov=%0d empty=%b required fe=%0d ov=%0d empty=1",
               fe_cnt, ov_cnt, empty, exp_fe, exp_ov);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got, exp;
    logic       was_empty;
    drive_frame(8'h5A, 1'b1, 10 * B, -1);
    model_frame(8'h5A, 1'b1, 1'b0);
    idle(4);
    drive_frame(8'hF0, 1'b1, 4 * B + B / 2, -1);
    checks++;
    if ({busy, empty} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL midframe_pre got busy=%b empty=%b required busy=1 empty=0", busy, empty);
    end
    @(negedge clk);
    rst_n  = 1'b0;
    rx_bit = 1'b1;
    #1;
    model_q.delete();
    checks++;
    if ({dout, empty, full, busy, frame_err, overrun} !== {8'h00, 5'b10000}) begin
      errors++;
      $display("[TB] FAIL midframe_reset got=%h required=%h", {dout, empty, full, busy, frame_err, overrun}, {8'h00, 5'b10000});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * B);
    drive_frame(8'hC3, 1'b1, 10 * B, -1);
    model_frame(8'hC3, 1'b1, 1'b0);
    idle(4);
    exp = model_q.pop_front();
    pop_byte(got, was_empty);
    checks++;
    if (was_empty !== 1'b0 || got !== exp) begin
      errors++;
      $display("[TB] FAIL midframe_next got %h (empty=%b) required %h", got, was_empty, exp);
    end
    @(negedge clk);
    checks++;
    if (empty !== 1'b1 || fe_cnt !== exp_fe || ov_cnt !== exp_ov) begin
      errors++;
      $display("[TB] FAIL midframe_final got empty=%b fe=%0d ov=%0d required empty=1 fe=%0d ov=%0d",
               empty, fe_cnt, ov_cnt, exp_fe, exp_ov);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rx_en  = 1'b1;
    rx_bit = 1'b1;
    rx_re  = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_random();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
